// File: rtl/cla_serial_adder_ctrl.sv
// cla_serial_adder_ctrl
// Serial adder that reuses one 4-bit carry-lookahead slice per clock. An
// accepted operand pair is summed one nibble per cycle, LSB nibble first. The
// result is then held in DONE until the consumer takes it.
module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    return {c[4], s};
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [KW+1:0]    nib_base_s;
  logic [4:0]       slice_s;

  // Select the current nibble of the latched operands and run it through the slice
  always_comb begin
    nib_base_s = {k_r, 2'b00};
    slice_s    = cla4(a_r[nib_base_s +: 4], b_r[nib_base_s +: 4], carry_r);
  end

  // Next-state decode; out_ready only matters in DONE, in_valid only in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == K_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, operand latch, carry chain and nibble-wise result write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      k_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            k_r     <= '0;
          end
        end
        RUN: begin
          sum_r[nib_base_s +: 4] <= slice_s[3:0];
          carry_r                <= slice_s[4];
          k_r                    <= k_r + KW'(1);
          if (k_r == K_LAST) begin
            cout_r <= slice_s[4];
          end
        end
        DONE: begin
          // result held until the consumer handshakes
        end
        default: begin
          // unreachable encoding; next-state logic returns to IDLE
        end
      endcase
    end
  end

  // Handshake and status flags decode directly from the state register
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
    busy      = (state_r == RUN) || (state_r == DONE);
    sum       = sum_r;
    cout      = cout_r;
  end

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Self-checking bench for cla_serial_adder_ctrl (WIDTH=16): directed scenarios
// with literal expectations plus randomized operations against a cycle model.
module tb_cla_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int vectors = 0;
  int errors  = 0;
  bit started = 1'b0;

  cla_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a countdown of remaining nibble cycles, plus a
  // pending result computed with plain integer addition.
  int               m_left  = 0;
  bit               m_done  = 1'b0;
  bit               m_known = 1'b0;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;
  logic [WIDTH:0]   m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_known = 1'b1;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1; m_known = 1'b1;
        m_sum = m_pend[WIDTH-1:0]; m_cout = m_pend[WIDTH];
      end
    end else if (in_valid) begin
      m_pend  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      m_left  = NIB;
      m_known = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  32'(in_ready),  32'(!m_done && m_left == 0));
      check("out_valid", 32'(out_valid), 32'(m_done));
      check("busy",      32'(busy),      32'(m_done || m_left > 0));
      if (m_known) begin
        check("sum",  32'(sum),  32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  // One operation: present operands, optionally poke in_valid during RUN,
  // wait for the result, hold off out_ready for 'hold' cycles, then drain.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input logic oc, input int hold, input bit intrude,
                       output logic [WIDTH-1:0] rsum, output logic rcout);
    logic [WIDTH:0] exp;
    int n;
    bit seen;
    exp = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, oc};
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    seen = 1'b0;
    n = 1;
    while (n <= 20 && !seen) begin
      if (intrude && n == 2) begin
        in_valid = 1'b1; a = 16'h0001; b = 16'h0000; cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (intrude && n >= 2) check("busy_run", 32'(busy), 32'd1);
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b0;
    check("result_seen", 32'(seen), 32'd1);
    check("latency", 32'(n - 1), 32'(NIB));
    rsum = sum; rcout = cout;
    check("op_sum",  32'(sum),  32'(exp[WIDTH-1:0]));
    check("op_cout", 32'(cout), 32'(exp[WIDTH]));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum",   32'(sum),       32'(rsum));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_drain", 32'(in_ready), 32'd1);
  endtask

  logic [WIDTH-1:0] rs;
  logic             rc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum",      32'(sum),      32'd0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, rs, rc);
    check("ffff_sum", 32'(rs), 32'h0000); check("ffff_cout", 32'(rc), 32'd1);
    do_op(16'h1234, 16'h4321, 1'b1, 1, 1'b0, rs, rc);
    check("1234_sum", 32'(rs), 32'h5556); check("1234_cout", 32'(rc), 32'd0);
    do_op(16'h0FFF, 16'h0000, 1'b1, 0, 1'b0, rs, rc);
    check("0fff_sum", 32'(rs), 32'h1000); check("0fff_cout", 32'(rc), 32'd0);
    do_op(16'hAAAA, 16'h5555, 1'b0, 5, 1'b0, rs, rc);
    check("bp_sum", 32'(rs), 32'hFFFF); check("bp_cout", 32'(rc), 32'd0);
    do_op(16'h0100, 16'h0020, 1'b0, 1, 1'b1, rs, rc);
    check("intrude_sum", 32'(rs), 32'h0120);

    // Reset at the second RUN edge, with in_valid also high
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready),  32'd1);
    check("abort_sum",   32'(sum),       32'd0);
    check("abort_cout",  32'(cout),      32'd0);
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    do_op(16'h0002, 16'h0003, 1'b0, 0, 1'b0, rs, rc);
    check("fresh_sum", 32'(rs), 32'h0005);

    // Randomized operations, some with in_valid noise or a mid-op reset
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'($urandom), rs, rc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder_ctrl.md
CLA_SERIAL_ADDER_CTRL -- requirements
Module: cla_serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4, at least 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  registered carry out of the MSB nibble.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL contain exactly one 4-bit carry-lookahead slice, reused once per cycle: G=a&b, P=a^b per bit, c[i+1]=G[i]|(P[i]&c[i]), s[i]=P[i]^c[i].
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-017 IDLE: on in_valid=1 at an edge, the block SHALL latch a, b and cin, clear nibble index k to 0, and enter RUN.
REQ-018 RUN: in_ready=0, busy=1, out_valid=0.
REQ-019 RUN, each edge: the slice SHALL add nibble k of the latched A and B with the carry register; the block SHALL write result bits [4k+3:4k] of sum, store the slice carry-out in the carry register, and increment k.
REQ-020 The carry register SHALL hold the latched cin on entry to RUN.
REQ-021 When k=WIDTH/4-1 is processed, the FSM SHALL go to DONE; cout SHALL take that slice's carry-out at the same edge.
REQ-022 Latency: out_valid SHALL rise exactly WIDTH/4 edges after the accepting edge (4 for WIDTH=16).
REQ-023 DONE: out_valid=1, busy=1, in_ready=0; sum and cout SHALL hold stable while out_ready=0, for any number of cycles.
REQ-024 DONE: on out_ready=1 at an edge, the FSM SHALL return to IDLE; in_ready SHALL be 1 in the following cycle. There is no same-cycle drain-and-accept.
REQ-025 in_valid, a, b and cin SHALL be ignored whenever in_ready=0; latched operands SHALL not change in RUN or DONE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Lower sum bits not yet written in RUN SHALL hold their previous value; sum is defined only while out_valid=1.
REQ-028 Arithmetic SHALL wrap mod 2^WIDTH; overflow is reported only through cout; there is no signed interpretation.

Reset
REQ-029 When rst=1 at an edge, the FSM SHALL go to IDLE with in_ready=1, out_valid=0, busy=0, sum=0, cout=0, k=0 and carry register=0.
REQ-030 Reset SHALL take priority over every other event, including in_valid and out_ready in the same cycle.
REQ-031 Reset mid-RUN or in DONE SHALL abort the operation with no result emitted; the first accept after reset release SHALL behave as from power-up.
REQ-032 in_valid=1 during a cycle with rst=1 SHALL not be accepted.

Verification
REQ-033 The bench SHALL cover these scenarios (WIDTH=16):
- a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 edges after accept; sum=0x0000, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; carry propagates through no nibble boundary.
- a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0; checks the carry register across all three nibble boundaries.
- Backpressure: result 0xAAAA+0x5555, cin=0, out_ready held low 5 cycles -> sum=0xFFFF, cout=0 held stable and out_valid=1 throughout; in_ready=1 one cycle after the out_ready handshake.
- in_valid with a=0x0001 asserted during RUN -> ignored; the original result is unchanged and busy stays 1.
- rst pulsed at the second RUN edge -> next cycle out_valid=0, in_ready=1, sum=0, cout=0; a fresh 0x0002+0x0003 yields 0x0005.
